alu_req_arbiter: RTL and testbench

- Shares one alu_1 instance among NUM_REQ sub-action lanes of an action stage.
- Round-robin arbitration over valid/ready request ports; issues one ALU operation per cycle.
- Tracks in-flight lane IDs in order and routes each ALU result back to its originating lane.

---
 rtl/alu_req_arbiter_if.sv | 43 ++++
 rtl/alu_req_arbiter.sv | 116 +++++++++++
 tb/tb_alu_req_arbiter.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_req_arbiter_if.sv
// Bundle of request, ALU-side and response signals shared between the lane
// requesters / alu_1 (master) and the arbiter (slave).
interface alu_req_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int ID_W       = 2,
   parameter int ACTION_LEN = 25,
   parameter int DATA_WIDTH = 48
);
   // Handshake: lane i transfers when req_valid[i] & req_ready[i] at a rising
   // clk edge; a requester holds action/operands stable while valid and not ready.
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0]            req_ready;
   logic [NUM_REQ*ACTION_LEN-1:0] req_action;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_op1;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_op2;
   logic [ACTION_LEN-1:0]         alu_action_out;
   logic                          alu_action_valid;
   logic [DATA_WIDTH-1:0]         alu_operand_1_out;
   logic [DATA_WIDTH-1:0]         alu_operand_2_out;
   logic [DATA_WIDTH-1:0]         alu_container_in;
   logic                          alu_container_valid;
   logic [NUM_REQ-1:0]            rsp_valid;
   logic [DATA_WIDTH-1:0]         rsp_data;
   logic [ID_W-1:0]               rsp_id;
   logic                          busy;
   logic                          err_unexpected;

   modport master (
      output req_valid, req_action, req_op1, req_op2,
      output alu_container_in, alu_container_valid,
      input  req_ready, alu_action_out, alu_action_valid,
      input  alu_operand_1_out, alu_operand_2_out,
      input  rsp_valid, rsp_data, rsp_id, busy, err_unexpected
   );

   modport slave (
      input  req_valid, req_action, req_op1, req_op2,
      input  alu_container_in, alu_container_valid,
      output req_ready, alu_action_out, alu_action_valid,
      output alu_operand_1_out, alu_operand_2_out,
      output rsp_valid, rsp_data, rsp_id, busy, err_unexpected
   );
endinterface

// File: rtl/alu_req_arbiter.sv
// Round-robin sharing of one alu_1 among NUM_REQ lanes; an in-order ID FIFO
// steers each ALU result back to the lane that issued it.
module alu_req_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int ID_W         = 2,
   parameter int ACTION_LEN   = 25,
   parameter int DATA_WIDTH   = 48,
   parameter int MAX_INFLIGHT = 4
) (
   input logic clk,
   input logic rst,
   alu_req_arbiter_if.slave bus
);
   localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
   localparam int PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;

   logic [ID_W-1:0]       ptr_q, ptr_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [ID_W-1:0]       fifo_q [MAX_INFLIGHT];
   logic [PTR_W-1:0]      wr_q, rd_q;
   logic                  iss_valid_q;
   logic [ACTION_LEN-1:0] iss_action_q;
   logic [DATA_WIDTH-1:0] iss_op1_q, iss_op2_q;
   logic [NUM_REQ-1:0]    rsp_valid_q;
   logic [DATA_WIDTH-1:0] rsp_data_q;
   logic [ID_W-1:0]       rsp_id_q;
   logic                  err_q;

   logic                  gnt_found;
   logic [ID_W-1:0]       gnt_id;
   logic                  can_issue, hs, pop;
   logic [ACTION_LEN-1:0] sel_action;
   logic [DATA_WIDTH-1:0] sel_op1, sel_op2;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(MAX_INFLIGHT - 1)) ? '0 : p + 1'b1;
   endfunction

   // First valid lane at or after the RR pointer, wrapping.
   always_comb begin
      logic [ID_W-1:0] cand;
      gnt_found = 1'b0;
      gnt_id    = '0;
      cand      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = ID_W'((int'(ptr_q) + k) % NUM_REQ);
         if (!gnt_found && bus.req_valid[cand]) begin
            gnt_found = 1'b1;
            gnt_id    = cand;
         end
      end
   end

   // A pop in the same cycle deliberately does not free a slot for issue.
   assign can_issue     = (cnt_q != CNT_W'(MAX_INFLIGHT));
   assign hs            = gnt_found && can_issue;
   assign pop           = bus.alu_container_valid && (cnt_q != '0);
   assign bus.req_ready = hs ? (NUM_REQ'(1) << gnt_id) : '0;

   always_comb begin
      sel_action = bus.req_action[gnt_id*ACTION_LEN +: ACTION_LEN];
      sel_op1    = bus.req_op1[gnt_id*DATA_WIDTH +: DATA_WIDTH];
      sel_op2    = bus.req_op2[gnt_id*DATA_WIDTH +: DATA_WIDTH];
      ptr_d      = hs ? ID_W'((int'(gnt_id) + 1) % NUM_REQ) : ptr_q;
      cnt_d      = cnt_q;
      if (hs && !pop)      cnt_d = cnt_q + 1'b1;
      else if (!hs && pop) cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q        <= '0;
         cnt_q        <= '0;
         wr_q         <= '0;
         rd_q         <= '0;
         for (int i = 0; i < MAX_INFLIGHT; i++) fifo_q[i] <= '0;
         iss_valid_q  <= 1'b0;
         iss_action_q <= '0;
         iss_op1_q    <= '0;
         iss_op2_q    <= '0;
         rsp_valid_q  <= '0;
         rsp_data_q   <= '0;
         rsp_id_q     <= '0;
         err_q        <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
         if (hs) begin
            fifo_q[wr_q] <= gnt_id;
            wr_q         <= ptr_inc(wr_q);
         end
         if (pop) rd_q <= ptr_inc(rd_q);
         iss_valid_q  <= hs;
         iss_action_q <= hs ? sel_action : '0;
         iss_op1_q    <= hs ? sel_op1 : '0;
         iss_op2_q    <= hs ? sel_op2 : '0;
         rsp_valid_q  <= pop ? (NUM_REQ'(1) << fifo_q[rd_q]) : '0;
         if (pop) begin
            rsp_data_q <= bus.alu_container_in;
            rsp_id_q   <= fifo_q[rd_q];
         end
         // A result with nothing outstanding is dropped and flagged until reset.
         if (bus.alu_container_valid && !pop) err_q <= 1'b1;
      end
   end

   assign bus.alu_action_valid  = iss_valid_q;
   assign bus.alu_action_out    = iss_action_q;
   assign bus.alu_operand_1_out = iss_op1_q;
   assign bus.alu_operand_2_out = iss_op2_q;
   assign bus.rsp_valid         = rsp_valid_q;
   assign bus.rsp_data          = rsp_data_q;
   assign bus.rsp_id            = rsp_id_q;
   assign bus.busy              = (cnt_q != '0) || iss_valid_q;
   assign bus.err_unexpected    = err_q;
endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter with a variable-latency alu_1 stub and
// an in-order response scoreboard.
module tb_alu_req_arbiter;
   localparam int NUM_REQ = 4;
   localparam int ID_W    = 2;
   localparam int AL      = 25;
   localparam int DW      = 48;
   localparam int MAXI    = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   alu_req_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .ACTION_LEN(AL), .DATA_WIDTH(DW)) bus ();

   alu_req_arbiter #(
      .NUM_REQ(NUM_REQ), .ID_W(ID_W), .ACTION_LEN(AL), .DATA_WIDTH(DW), .MAX_INFLIGHT(MAXI)
   ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   // ---------------- alu_1 stub: opcode 1 add, 2 sub, else xor ----------------
   int             alu_lat = 1;
   logic           inj_valid = 1'b0;
   logic [7:0]     pv_q;
   logic [DW-1:0]  pd_q [8];

   function automatic logic [DW-1:0] alu_f(input logic [AL-1:0] act, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
      case (act[24:21])
         4'd1:    return a + b;
         4'd2:    return a - b;
         default: return a ^ b;
      endcase
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pv_q <= '0;
         for (int i = 0; i < 8; i++) pd_q[i] <= '0;
      end else begin
         pv_q    <= {pv_q[6:0], bus.alu_action_valid};
         pd_q[0] <= alu_f(bus.alu_action_out, bus.alu_operand_1_out, bus.alu_operand_2_out);
         for (int i = 1; i < 8; i++) pd_q[i] <= pd_q[i-1];
      end
   end

   assign bus.alu_container_valid = pv_q[alu_lat-1] | inj_valid;
   assign bus.alu_container_in    = pd_q[alu_lat-1];

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- scoreboard ----------------
   logic [ID_W+DW-1:0] exp_q[$];

   task automatic exp_push(input int id, input logic [DW-1:0] data);
      exp_q.push_back({ID_W'(id), data});
   endtask

   always @(negedge clk) begin
      logic [ID_W+DW-1:0] e;
      if (!rst && bus.rsp_valid != '0) begin
         if (exp_q.size() == 0) begin
            check("rsp_unexpected", 64'(bus.rsp_valid), 64'd0);
         end else begin
            e = exp_q.pop_front();
            check("rsp_id", 64'(bus.rsp_id), 64'(e[ID_W+DW-1:DW]));
            check("rsp_data", 64'(bus.rsp_data), 64'(e[DW-1:0]));
            check("rsp_onehot", 64'(bus.rsp_valid), 64'(4'b0001 << e[ID_W+DW-1:DW]));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_lane(input int i, input logic v, input logic [3:0] op,
                             input logic [DW-1:0] a, input logic [DW-1:0] b);
      bus.req_valid[i]           = v;
      bus.req_action[i*AL +: AL] = {op, 21'h89};
      bus.req_op1[i*DW +: DW]    = a;
      bus.req_op2[i*DW +: DW]    = b;
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      inj_valid  = 1'b0;
      bus.req_valid  = '0;
      bus.req_action = '0;
      bus.req_op1    = '0;
      bus.req_op2    = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      do_reset();
      rst = 1'b1;
      #2;
      check("rst_action_valid", 64'(bus.alu_action_valid), 64'd0);
      check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_err", 64'(bus.err_unexpected), 64'd0);
      check("rst_ready", 64'(bus.req_ready), 64'd0);
      step();
      rst = 1'b0;

      // 1: lane 0 ADD 1+3, full latency trace
      drive_lane(0, 1'b1, 4'd1, 48'd1, 48'd3);
      exp_push(0, 48'd4);
      @(negedge clk);
      check("t1_ready", 64'(bus.req_ready), 64'h1);
      step();
      drive_lane(0, 1'b0, 4'd0, 48'd0, 48'd0);
      @(negedge clk);
      check("t1_act_valid", 64'(bus.alu_action_valid), 64'd1);
      check("t1_act", 64'(bus.alu_action_out), 64'({4'b0001, 21'h89}));
      check("t1_op1", 64'(bus.alu_operand_1_out), 64'd1);
      check("t1_op2", 64'(bus.alu_operand_2_out), 64'd3);
      check("t1_busy", 64'(bus.busy), 64'd1);
      step();
      @(negedge clk);
      check("t1_act_idle", 64'(bus.alu_action_valid), 64'd0);
      check("t1_act_zero", 64'(bus.alu_action_out), 64'd0);
      check("t1_op1_zero", 64'(bus.alu_operand_1_out), 64'd0);
      step();
      @(negedge clk);
      check("t1_rsp_at_3", 64'(bus.rsp_valid), 64'h1);
      step();
      @(negedge clk);
      check("t1_rsp_drop", 64'(bus.rsp_valid), 64'd0);
      check("t1_rsp_hold", 64'(bus.rsp_data), 64'd4);
      check("t1_busy_clr", 64'(bus.busy), 64'd0);

      // 2: lane 2 SUB 20-3 (pointer now 1, so scan 1,2 finds lane 2)
      step();
      drive_lane(2, 1'b1, 4'd2, 48'd20, 48'd3);
      exp_push(2, 48'd17);
      @(negedge clk);
      check("t2_ready", 64'(bus.req_ready), 64'h4);
      step();
      drive_lane(2, 1'b0, 4'd0, 48'd0, 48'd0);
      idle(5);

      // 3: all lanes from reset, grants 0..3 back to back
      do_reset();
      for (int i = 0; i < NUM_REQ; i++) drive_lane(i, 1'b1, 4'd1, 48'(10*i+1), 48'(i));
      for (int k = 0; k < NUM_REQ; k++) begin
         @(negedge clk);
         check("t3_ready", 64'(bus.req_ready), 64'(4'b0001 << k));
         exp_push(k, 48'(11*k+1));
         step();
         drive_lane(k, 1'b0, 4'd0, 48'd0, 48'd0);
      end
      idle(6);

      // 4: lanes 1 and 3 held valid alternate
      do_reset();
      drive_lane(1, 1'b1, 4'd1, 48'd5, 48'd6);
      drive_lane(3, 1'b1, 4'd2, 48'd100, 48'd1);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("t4_ready", 64'(bus.req_ready), (k % 2 == 0) ? 64'h2 : 64'h8);
         if (k % 2 == 0) exp_push(1, 48'd11);
         else            exp_push(3, 48'd99);
         step();
      end
      drive_lane(1, 1'b0, 4'd0, 48'd0, 48'd0);
      drive_lane(3, 1'b0, 4'd0, 48'd0, 48'd0);
      idle(6);

      // 5: ALU_LAT=6, in-flight limit stalls issue until one cycle after first pop
      rst = 1'b1;
      alu_lat = 6;
      do_reset();
      for (int i = 0; i < NUM_REQ; i++) drive_lane(i, 1'b1, 4'd1, 48'(100+i), 48'(i));
      for (int c = 0; c < 9; c++) begin
         logic [3:0] er;
         er = (c < 4) ? (4'b0001 << c) : ((c == 8) ? 4'b0001 : 4'b0000);
         @(negedge clk);
         check("t5_ready", 64'(bus.req_ready), 64'(er));
         if (c < 4)  exp_push(c, 48'(100 + 2*c));
         if (c == 8) exp_push(0, 48'd100);
         step();
      end
      bus.req_valid = '0;
      @(negedge clk);
      check("t5_busy", 64'(bus.busy), 64'd1);
      idle(16);
      @(negedge clk);
      check("t5_busy_clr", 64'(bus.busy), 64'd0);
      check("drain_pre_t6", 64'(exp_q.size()), 64'd0);

      // 6: stray result, then reset with ops in flight
      rst = 1'b1;
      alu_lat = 1;
      do_reset();
      inj_valid = 1'b1;
      step();
      inj_valid = 1'b0;
      @(negedge clk);
      check("t6_err_set", 64'(bus.err_unexpected), 64'd1);
      check("t6_no_rsp", 64'(bus.rsp_valid), 64'd0);
      check("t6_busy", 64'(bus.busy), 64'd0);
      idle(3);
      @(negedge clk);
      check("t6_err_sticky", 64'(bus.err_unexpected), 64'd1);
      step();
      alu_lat = 6;
      drive_lane(0, 1'b1, 4'd1, 48'd7, 48'd7);
      drive_lane(1, 1'b1, 4'd1, 48'd8, 48'd8);
      idle(2);
      bus.req_valid = '0;
      @(negedge clk);
      check("t6_inflight_busy", 64'(bus.busy), 64'd1);
      step();
      rst = 1'b1;
      #1;
      check("t6_rst_busy", 64'(bus.busy), 64'd0);
      check("t6_rst_act", 64'(bus.alu_action_valid), 64'd0);
      check("t6_rst_err", 64'(bus.err_unexpected), 64'd0);
      check("t6_rst_rsp_data", 64'(bus.rsp_data), 64'd0);
      step();
      rst = 1'b0;
      idle(10);
      @(negedge clk);
      check("t6_post_busy", 64'(bus.busy), 64'd0);
      check("drain", 64'(exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
